ssd_scan_decoder: RTL and testbench
===================================

Name: ssd_scan_decoder

Overview:
Receive-side counterpart of the 4-digit multiplexed seven-segment driver. Samples the active-low anode and cathode lines, in the same form the top level drives them, and decodes each segment pattern back to a hex nibble. Reassembles complete, stable 16-bit frames. Used as an on-board loopback monitor and as the display checker in system benches.

Parameters:
SETTLE_CYC, 16, consecutive cycles an anode/cathode pair must hold unchanged before the digit is sampled (range 1..255)
STABLE_FRAMES, 2, consecutive identical complete frames required before frame_word updates (range 1..15)

Ports:
board_clk  in  1  system clock, 100 MHz
Reset  in  1  asynchronous, active-high reset
An  in  4  anodes {An3,An2,An1,An0}, active-low, asynchronous to decoder
Cath  in  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, asynchronous
digits_out  out  16  last decoded nibble per digit {d3,d2,d1,d0}
digit_valid  out  4  per-digit flag: last sample decoded to a legal hex glyph
dp_out  out  4  captured Dp per digit, 1 = lit
frame_word  out  16  last accepted stable frame
frame_strobe  out  1  one-cycle pulse when frame_word is written
frame_changed  out  1  one-cycle pulse with frame_strobe when the new value differs from the previous frame_word
decode_err  out  1  one-cycle pulse on an illegal non-blank pattern
err_count  out  8  saturating count of decode_err pulses

Behaviour:
- Reset: all outputs 0, FSM in IDLE, settle counter 0, frame mask 0, match count 0, candidate 0.
- Synchronisation: An and Cath pass through 2-FF synchronisers. All timing below is counted from the synchronised values.
- Anode classification: exactly one bit low selects digit index 3..0. Zero bits low or more than one bit low is a "no-digit" condition. No-digit forces IDLE and is not an error.
- FSM states:
  - IDLE: on a valid anode, load counter and go to SETTLE.
  - SETTLE: if the anode or the 7 segment bits change, restart the counter and stay in SETTLE; on no-digit, go to IDLE. After SETTLE_CYC unchanged cycles, sample and go to HOLD.
  - HOLD: exactly one sample per anode activation. Stay until the anode changes; then go to SETTLE for a new digit, or to IDLE on no-digit.
- Sampling latency: 2 + SETTLE_CYC cycles after both inputs settle.
- Decode (abcdefg active-low), inverse of driver table:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=B, 0110001=C, 1000010=D, 0110000=E, 0111000=F.
  - 1111111 = blank: digit_valid cleared, no error.
  - Any other pattern: digit_valid cleared, decode_err pulses, err_count increments and saturates at 255.
- Per-digit update: digits_out nibble is written only on a legal decode; otherwise it holds its previous value.
- Frame assembly:
  - The scan order is d3, d2, d1, d0.
  - Sampling d3 starts a new frame, clearing the mask and setting bit 3.
  - A sample of the next expected digit sets its mask bit.
  - An out-of-order sample (skip or repeat) aborts the frame and clears the mask. It leaves the match count unchanged.
  - A blank or illegal digit anywhere in a frame marks that frame invalid.
- Frame completion: on the d0 sample with all 4 mask bits set:
  - Invalid frame: match count resets to 0.
  - Value equals candidate: match count increments, saturating at STABLE_FRAMES.
  - Value differs from candidate: the value becomes the new candidate and match count is set to 1.
  - When match count reaches STABLE_FRAMES, frame_word is written and frame_strobe pulses. frame_changed pulses only if the value differs from the old frame_word.
  - Further identical frames do not re-strobe until the candidate changes.
- Simultaneous events: a decode_err and a frame completion in the same cycle are both reported. Reset asserted mid-frame clears all state, and the next frame must begin at d3.

Optional Feature:
SSD_DP_CAPTURE_EN
- Defined: dp_out registers the inverted Dp on each sample. The 4 Dp bits are part of the candidate/frame comparison, and a Dp change restarts settling.
- Undefined: Dp is ignored entirely and dp_out is tied to 0.

Test Plan:
- Drive "12AB", each digit held 64 cycles in order An3..An0, repeated 3 frames -> digits_out=16'h12AB; frame_word=16'h12AB with one frame_strobe and frame_changed at end of frame 2; no strobe in frame 3.
- Steady "12AB" then switch to "0000" -> frame_word=16'h0000 after 2 frames of "0000", frame_changed=1.
- Digit d1 held for only SETTLE_CYC-1 cycles -> no d1 sample, frame aborted, frame_word unchanged.
- Cathode pattern 1010101 on d2 -> decode_err pulse, err_count=1, digit_valid[2]=0, frame not accepted; 300 such errors -> err_count=255.
- Anode sequence An3, An1 (skip An2) -> frame discarded; An=4'b0011 (two low) -> IDLE, no error.
- Assert Reset during d1 of a "5A5A" stream -> all outputs 0; frame_word=16'h5A5A only after 2 full new frames starting from d3.

Source files
------------

// File: rtl/ssd_scan_decoder.sv
// Loopback decoder for a 4-digit multiplexed seven-segment display: samples the
// active-low An/Cath lines and rebuilds stable 16-bit frames. Optional: SSD_DP_CAPTURE_EN.
module ssd_scan_decoder #(
  parameter int unsigned SETTLE_CYC    = 16,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic        board_clk,
  input  logic        Reset,
  input  logic [3:0]  An,
  input  logic [7:0]  Cath,
  output logic [15:0] digits_out,
  output logic [3:0]  digit_valid,
  output logic [3:0]  dp_out,
  output logic [15:0] frame_word,
  output logic        frame_strobe,
  output logic        frame_changed,
  output logic        decode_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] STABLE_MAX  = 4'(STABLE_FRAMES);

`ifdef SSD_DP_CAPTURE_EN
  localparam int         FW       = 20;
  localparam logic [7:0] CMP_MASK = 8'hFF;
`else
  localparam int         FW       = 16;
  localparam logic [7:0] CMP_MASK = 8'hFE;
`endif

  state_t          state, state_nx;
  logic [3:0]      an_meta, an_sync, an_ref;
  logic [7:0]      cath_meta, cath_sync, cath_ref;
  logic [7:0]      cnt;
  logic            digit_sel, pair_changed, restart, sample;
  logic [1:0]      digit_idx;
  logic            legal, blank, illegal, expected, cand_new, strobe_nx, done_bad;
  logic [3:0]      nib, mask, match, match_nx;
  logic [15:0]     acc_nib;
  logic            frame_bad;
  logic [FW-1:0]   cand, done_val;

  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'b0000001: return 5'h10; 7'b1001111: return 5'h11;
      7'b0010010: return 5'h12; 7'b0000110: return 5'h13;
      7'b1001100: return 5'h14; 7'b0100100: return 5'h15;
      7'b0100000: return 5'h16; 7'b0001111: return 5'h17;
      7'b0000000: return 5'h18; 7'b0000100: return 5'h19;
      7'b0001000: return 5'h1A; 7'b1100000: return 5'h1B;
      7'b0110001: return 5'h1C; 7'b1000010: return 5'h1D;
      7'b0110000: return 5'h1E; 7'b0111000: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  // Inputs idle high so the synchronisers come out of reset showing no digit.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      an_meta   <= 4'hF;
      an_sync   <= 4'hF;
      cath_meta <= 8'hFF;
      cath_sync <= 8'hFF;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, which is what builds the two-stage chain.
      an_meta   <= An;
      an_sync   <= an_meta;
      cath_meta <= Cath;
      cath_sync <= cath_meta;
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (latch).
    digit_sel = 1'b1;
    digit_idx = 2'd0;
    case (an_sync)
      4'b0111: digit_idx = 2'd3;
      4'b1011: digit_idx = 2'd2;
      4'b1101: digit_idx = 2'd1;
      4'b1110: digit_idx = 2'd0;
      default: digit_sel = 1'b0;
    endcase
  end

  assign pair_changed = (an_sync != an_ref) || ((cath_sync & CMP_MASK) != (cath_ref & CMP_MASK));

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    sample   = 1'b0;
    case (state)
      IDLE: if (digit_sel) begin
        restart  = 1'b1;
        state_nx = SETTLE;
      end
      SETTLE: begin
        if (!digit_sel)             state_nx = IDLE;
        else if (pair_changed)      restart  = 1'b1;
        else if (cnt == SETTLE_LAST) begin
          sample   = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: if (an_sync != an_ref) begin
        if (!digit_sel) state_nx = IDLE;
        else begin
          restart  = 1'b1;
          state_nx = SETTLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign {legal, nib} = decode_seg(cath_sync[7:1]);
  assign blank        = (cath_sync[7:1] == 7'h7F);
  assign illegal      = !legal && !blank;
  assign expected     = (digit_idx == 2'd2 && mask == 4'b1000) ||
                        (digit_idx == 2'd1 && mask == 4'b1100) ||
                        (digit_idx == 2'd0 && mask == 4'b1110);
  assign done_bad     = frame_bad || !legal;

`ifdef SSD_DP_CAPTURE_EN
  logic [3:0] acc_dp, dp_q;
  assign done_val = {acc_dp[3:1], ~cath_sync[0], acc_nib[15:4], nib};
  assign dp_out   = dp_q;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      acc_dp <= '0;
      dp_q   <= '0;
    end else if (sample) begin
      acc_dp[digit_idx] <= ~cath_sync[0];
      dp_q[digit_idx]   <= ~cath_sync[0];
    end
  end
`else
  assign done_val = {acc_nib[15:4], nib};
  assign dp_out   = 4'h0;
`endif

  // Strobe only on the transition into "stable", or when a new candidate is already stable.
  always_comb begin
    cand_new = 1'b0;
    if (done_bad)              match_nx = 4'd0;
    else if (done_val == cand) match_nx = (match == STABLE_MAX) ? match : match + 4'd1;
    else begin
      match_nx = 4'd1;
      cand_new = 1'b1;
    end
    strobe_nx = !done_bad && (match_nx == STABLE_MAX) && ((match != STABLE_MAX) || cand_new);
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0; an_ref <= '0; cath_ref <= '0;
      digits_out <= '0; digit_valid <= '0; err_count <= '0; decode_err <= 1'b0;
      mask <= '0; frame_bad <= 1'b0; acc_nib <= '0; match <= '0; cand <= '0;
      frame_word <= '0; frame_strobe <= 1'b0; frame_changed <= 1'b0;
    end else begin
      decode_err    <= 1'b0;
      frame_strobe  <= 1'b0;
      frame_changed <= 1'b0;
      if (restart) begin
        cnt      <= '0;
        an_ref   <= an_sync;
        cath_ref <= cath_sync;
      end else if (state == SETTLE) begin
        cnt <= cnt + 8'd1;
      end
      if (sample) begin
        if (legal) digits_out[{digit_idx, 2'b00} +: 4] <= nib;
        digit_valid[digit_idx] <= legal;
        if (illegal) begin
          decode_err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
        if (digit_idx == 2'd3) begin
          mask           <= 4'b1000;
          frame_bad      <= !legal;
          acc_nib[15:12] <= nib;
        end else if (expected && digit_idx == 2'd0) begin
          mask  <= '0;
          match <= match_nx;
          if (cand_new) cand <= done_val;
          if (strobe_nx) begin
            frame_word    <= done_val[15:0];
            frame_strobe  <= 1'b1;
            frame_changed <= (done_val[15:0] != frame_word);
          end
        end else if (expected) begin
          mask[digit_idx]                     <= 1'b1;
          frame_bad                           <= frame_bad || !legal;
          acc_nib[{digit_idx, 2'b00} +: 4]    <= nib;
        end else begin
          mask <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder: table of display frames plus hand-written
// sequences for short holds, illegal glyphs, scan-order faults and mid-frame reset.
module tb_ssd_scan_decoder;

  logic        board_clk = 1'b0;
  logic        Reset;
  logic [3:0]  An;
  logic [7:0]  Cath;
  logic [15:0] digits_out, frame_word;
  logic [3:0]  digit_valid, dp_out;
  logic        frame_strobe, frame_changed, decode_err;
  logic [7:0]  err_count;

  int n_vec = 0, n_err = 0;
  int n_strobe = 0, n_changed = 0, n_dec_err = 0, n_orphan = 0;

  ssd_scan_decoder dut (
    .board_clk(board_clk), .Reset(Reset), .An(An), .Cath(Cath),
    .digits_out(digits_out), .digit_valid(digit_valid), .dp_out(dp_out),
    .frame_word(frame_word), .frame_strobe(frame_strobe),
    .frame_changed(frame_changed), .decode_err(decode_err), .err_count(err_count)
  );

  always #5 board_clk = ~board_clk;

  always @(negedge board_clk) begin
    if (frame_strobe)                   n_strobe++;
    if (frame_changed)                  n_changed++;
    if (decode_err)                     n_dec_err++;
    if (frame_changed && !frame_strobe) n_orphan++;
  end

  typedef struct {
    logic [15:0] word;
    int          frames;
    logic [15:0] exp_frame;
    int          exp_strobes;
    int          exp_changes;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001; 4'h1: return 7'b1001111;
      4'h2: return 7'b0010010; 4'h3: return 7'b0000110;
      4'h4: return 7'b1001100; 4'h5: return 7'b0100100;
      4'h6: return 7'b0100000; 4'h7: return 7'b0001111;
      4'h8: return 7'b0000000; 4'h9: return 7'b0000100;
      4'hA: return 7'b0001000; 4'hB: return 7'b1100000;
      4'hC: return 7'b0110001; 4'hD: return 7'b1000010;
      4'hE: return 7'b0110000; default: return 7'b0111000;
    endcase
  endfunction

  task automatic drive(input logic [3:0] an, input logic [7:0] cath, input int cycles);
    An   = an;
    Cath = cath;
    repeat (cycles) @(negedge board_clk);
  endtask

  task automatic digit(input logic [1:0] idx, input logic [3:0] n, input int cycles);
    drive(~(4'b0001 << idx), {seg_of(n), 1'b1}, cycles);
  endtask

  task automatic frames(input logic [15:0] w, input int count);
    for (int f = 0; f < count; f++)
      for (int d = 3; d >= 0; d--) begin
        logic [1:0] idx;
        idx = 2'(d);
        digit(idx, w[4*d +: 4], 64);
      end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {digits_out, digit_valid, dp_out, frame_word, frame_strobe,
                 frame_changed, decode_err, err_count}, 64'd0);
  endtask

  initial begin
    int s0, c0, e0;

    vecs[0]  = '{16'h12AB, 1, 16'h0000, 0, 0};
    vecs[1]  = '{16'h12AB, 1, 16'h12AB, 1, 1};
    vecs[2]  = '{16'h12AB, 1, 16'h12AB, 0, 0};
    vecs[3]  = '{16'h0000, 1, 16'h12AB, 0, 0};
    vecs[4]  = '{16'h0000, 1, 16'h0000, 1, 1};
    vecs[5]  = '{16'h5A5A, 2, 16'h5A5A, 1, 1};
    vecs[6]  = '{16'hC0DE, 2, 16'hC0DE, 1, 1};
    vecs[7]  = '{16'h89AB, 1, 16'hC0DE, 0, 0};
    vecs[8]  = '{16'hC0DE, 2, 16'hC0DE, 1, 0};
    vecs[9]  = '{16'h3467, 2, 16'h3467, 1, 1};
    vecs[10] = '{16'h79EF, 1, 16'h3467, 0, 0};

    An    = 4'hF;
    Cath  = 8'hFF;
    Reset = 1'b1;
    repeat (3) @(negedge board_clk);
    check_all_zero("reset_outputs");
    Reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      s0 = n_strobe;
      c0 = n_changed;
      frames(vecs[i].word, vecs[i].frames);
      check($sformatf("v%0d_digits", i), digits_out, vecs[i].word);
      check($sformatf("v%0d_valid", i), digit_valid, 4'hF);
      check($sformatf("v%0d_frame_word", i), frame_word, vecs[i].exp_frame);
      check($sformatf("v%0d_strobes", i), n_strobe - s0, vecs[i].exp_strobes);
      check($sformatf("v%0d_changes", i), n_changed - c0, vecs[i].exp_changes);
    end

    // d1 shown for one cycle too few: never sampled, frame aborted
    s0 = n_strobe;
    for (int f = 0; f < 2; f++) begin
      digit(2'd3, 4'h1, 64);
      digit(2'd2, 4'h2, 64);
      digit(2'd1, 4'h3, 15);
      digit(2'd0, 4'h4, 64);
    end
    check("short_d1_digits", digits_out, 16'h12E4);
    check("short_d1_frame_word", frame_word, 16'h3467);
    check("short_d1_strobes", n_strobe - s0, 0);

    // illegal glyph 1010101 on d2
    s0 = n_strobe;
    e0 = n_dec_err;
    digit(2'd3, 4'h1, 64);
    drive(4'b1011, {7'b1010101, 1'b1}, 64);
    digit(2'd1, 4'h3, 64);
    digit(2'd0, 4'h4, 64);
    check("illegal_err_count", err_count, 8'd1);
    check("illegal_err_pulses", n_dec_err - e0, 1);
    check("illegal_valid", digit_valid, 4'b1011);
    check("illegal_digits", digits_out, 16'h1234);
    digit(2'd3, 4'h1, 64);
    drive(4'b1011, {7'b1010101, 1'b1}, 64);
    digit(2'd1, 4'h3, 64);
    digit(2'd0, 4'h4, 64);
    check("illegal_err_count2", err_count, 8'd2);
    check("illegal_no_strobe", n_strobe - s0, 0);
    check("illegal_frame_word", frame_word, 16'h3467);

    e0 = n_dec_err;
    for (int i = 0; i < 300; i++) begin
      drive(4'b1011, {7'b1010101, 1'b1}, 24);
      drive(4'hF, 8'hFF, 4);
    end
    check("err_count_saturated", err_count, 8'd255);
    check("err_pulses_300", n_dec_err - e0, 300);

    // scan-order skip (d2 missing), then two anodes low at once
    s0 = n_strobe;
    e0 = n_dec_err;
    for (int f = 0; f < 2; f++) begin
      digit(2'd3, 4'h1, 64);
      digit(2'd1, 4'hA, 64);
      digit(2'd0, 4'hB, 64);
    end
    check("skip_no_strobe", n_strobe - s0, 0);
    check("skip_frame_word", frame_word, 16'h3467);
    check("skip_digits", digits_out, 16'h12AB);
    check("skip_valid", digit_valid, 4'b1011);
    drive(4'b0011, {seg_of(4'h8), 1'b1}, 64);
    check("two_low_no_err", n_dec_err - e0, 0);
    check("two_low_digits", digits_out, 16'h12AB);

    // reset in the middle of d1 of a "5A5A" stream
    frames(16'h5A5A, 1);
    digit(2'd3, 4'h5, 64);
    digit(2'd2, 4'hA, 64);
    digit(2'd1, 4'h5, 30);
    Reset = 1'b1;
    @(negedge board_clk);
    check_all_zero("mid_reset_outputs");
    repeat (4) @(negedge board_clk);
    Reset = 1'b0;
    s0 = n_strobe;
    c0 = n_changed;
    digit(2'd1, 4'h5, 34);
    digit(2'd0, 4'hA, 64);
    check("post_reset_digits", digits_out, 16'h005A);
    check("post_reset_valid", digit_valid, 4'b0011);
    check("post_reset_err_count", err_count, 8'd0);
    frames(16'h5A5A, 1);
    check("post_reset_one_frame", frame_word, 16'h0000);
    check("post_reset_no_strobe", n_strobe - s0, 0);
    frames(16'h5A5A, 1);
    check("post_reset_frame_word", frame_word, 16'h5A5A);
    check("post_reset_strobe", n_strobe - s0, 1);
    check("post_reset_changed", n_changed - c0, 1);
    check("dp_out_zero", dp_out, 4'h0);
    check("changed_without_strobe", n_orphan, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
